// File: rtl/hd44780_rx_pkg.sv
// Shared types and command-set constants for the HD44780 receiver model.
package hd44780_pkg;

  typedef enum logic [1:0] {
    MODE8    = 2'd0,
    MODE4_HI = 2'd1,
    MODE4_LO = 2'd2
  } rx_state_e;

  localparam logic [7:0] CMD_CLEAR       = 8'h01;
  localparam logic [6:0] CMD_HOME_PREFIX = 7'b0000001;
  localparam logic [5:0] CMD_ENTRY_PREFIX = 6'b000001;
  localparam logic [2:0] CMD_FUNCSET_PREFIX = 3'b001;
  localparam int         CMD_SETDDRAM_BIT = 7;

  localparam int DL_BIT = 4;
  localparam int ID_BIT = 1;

  function automatic logic is_funcset(input logic [7:0] b);
    return b[7:5] == CMD_FUNCSET_PREFIX;
  endfunction

endpackage

// File: rtl/hd44780_rx_if.sv
// HD44780 parallel bus (E/RS/DB[7:4]) as seen between the driver and the receiver.
interface hd44780_rx_if;
  logic       e;
  logic       rs;
  logic [3:0] db;

  modport master (output e, output rs, output db);
  modport slave  (input e, input rs, input db);
endinterface

// File: rtl/hd44780_rx_sync.sv
// Input conditioning and E falling-edge detect; HD44780_RX_SYNC_EN adds two-flop
// synchronizers on e/rs/db so rs/db keep the same pipeline depth as e.
module hd44780_rx_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       e,
  input  logic       rs,
  input  logic [3:0] db,
  output logic       fall,
  output logic       rs_s,
  output logic [3:0] db_s
);

  logic e_s;
  logic e_prev_q, e_prev_d;

`ifdef HD44780_RX_SYNC_EN
  logic [5:0] meta_q, meta_d;
  logic [5:0] sync_q, sync_d;

  assign meta_d = {e, rs, db};
  assign sync_d = meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign e_s  = sync_q[5];
  assign rs_s = sync_q[4];
  assign db_s = sync_q[3:0];
`else
  assign e_s  = e;
  assign rs_s = rs;
  assign db_s = db;
`endif

  assign e_prev_d = e_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) e_prev_q <= 1'b0;
    else     e_prev_q <= e_prev_d;
  end

  assign fall = e_prev_q & ~e_s;

endmodule

// File: rtl/hd44780_rx.sv
// HD44780 receiver: reassembles bytes in 8/4-bit mode and drives a DDRAM write port.
// Define HD44780_RX_SYNC_EN for asynchronous bus pins (3-cycle latency instead of 1).
module hd44780_rx
  import hd44780_pkg::*;
#(
  parameter int         LINE_LEN   = 40,
  parameter logic [6:0] LINE2_BASE = 7'h40
) (
  input  logic         clk,
  input  logic         rst,
  hd44780_rx_if.slave  lcd,
  output logic         byte_valid,
  output logic         byte_rs,
  output logic [7:0]   byte_data,
  output logic         wr_en,
  output logic [6:0]   wr_addr,
  output logic [7:0]   wr_data,
  output logic [6:0]   ddram_addr,
  output logic         mode4,
  output logic         clear_pulse
);

  localparam logic [6:0] LINE1_LAST = 7'(LINE_LEN - 1);
  localparam logic [6:0] LINE2_LAST = LINE2_BASE + 7'(LINE_LEN - 1);

  logic       fall, rs_s;
  logic [3:0] db_s;

  rx_state_e  state_q, state_d;
  logic [3:0] hi_q, hi_d;
  logic       id_q, id_d;
  logic [6:0] addr_q, addr_d;
  logic       byte_valid_q, byte_valid_d;
  logic       byte_rs_q, byte_rs_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       wr_en_q, wr_en_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       clear_q, clear_d;

  logic       asm_valid, asm_rs;
  logic [7:0] asm_byte;

  hd44780_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .e    (lcd.e),
    .rs   (lcd.rs),
    .db   (lcd.db),
    .fall (fall),
    .rs_s (rs_s),
    .db_s (db_s)
  );

  // Addresses live in two disjoint windows; stepping off either end hops to the other.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == LINE1_LAST)      return LINE2_BASE;
      else if (a == LINE2_LAST) return 7'h00;
      else                      return a + 7'd1;
    end else begin
      if (a == 7'h00)           return LINE2_LAST;
      else if (a == LINE2_BASE) return LINE1_LAST;
      else                      return a - 7'd1;
    end
  endfunction

  function automatic logic addr_in_range(input logic [6:0] a);
    return (a <= LINE1_LAST) || ((a >= LINE2_BASE) && (a <= LINE2_LAST));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= MODE8;
      hi_q         <= 4'h0;
      id_q         <= 1'b1;
      addr_q       <= 7'h00;
      byte_valid_q <= 1'b0;
      byte_rs_q    <= 1'b0;
      byte_data_q  <= 8'h00;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 7'h00;
      wr_data_q    <= 8'h00;
      clear_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      byte_valid_q <= byte_valid_d;
      byte_rs_q    <= byte_rs_d;
      byte_data_q  <= byte_data_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      clear_q      <= clear_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    asm_valid = 1'b0;
    asm_rs    = rs_s;
    asm_byte  = {db_s, 4'h0};
    if (fall) begin
      case (state_q)
        MODE8: begin
          asm_valid = 1'b1;
          if (!rs_s && is_funcset(asm_byte) && !asm_byte[DL_BIT]) state_d = MODE4_HI;
        end
        MODE4_HI: begin
          hi_d    = db_s;
          state_d = MODE4_LO;
        end
        MODE4_LO: begin
          asm_valid = 1'b1;
          asm_byte  = {hi_q, db_s};
          state_d   = MODE4_HI;
          if (!rs_s && is_funcset(asm_byte) && asm_byte[DL_BIT]) state_d = MODE8;
        end
        default: state_d = MODE8;
      endcase
    end
  end

  always_comb begin
    addr_d       = addr_q;
    id_d         = id_q;
    byte_valid_d = 1'b0;
    byte_rs_d    = byte_rs_q;
    byte_data_d  = byte_data_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    clear_d      = 1'b0;
    if (asm_valid) begin
      byte_valid_d = 1'b1;
      byte_rs_d    = asm_rs;
      byte_data_d  = asm_byte;
      if (asm_rs) begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = asm_byte;
        addr_d    = step_addr(addr_q, id_q);
      end else if (asm_byte == CMD_CLEAR) begin
        addr_d  = 7'h00;
        id_d    = 1'b1;
        clear_d = 1'b1;
      end else if (asm_byte[7:1] == CMD_HOME_PREFIX) begin
        addr_d = 7'h00;
      end else if (asm_byte[7:2] == CMD_ENTRY_PREFIX) begin
        id_d = asm_byte[ID_BIT];
      end else if (asm_byte[CMD_SETDDRAM_BIT]) begin
        if (addr_in_range(asm_byte[6:0])) addr_d = asm_byte[6:0];
      end
    end
  end

  assign byte_valid  = byte_valid_q;
  assign byte_rs     = byte_rs_q;
  assign byte_data   = byte_data_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign ddram_addr  = addr_q;
  assign mode4       = (state_q != MODE8);
  assign clear_pulse = clear_q;

endmodule

// File: tb/tb_hd44780_rx.sv
// Directed, table-driven bench for hd44780_rx: nibble vectors with hand-computed results.
module tb_hd44780_rx;

`ifdef HD44780_RX_SYNC_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic       byte_valid, byte_rs, wr_en, mode4, clear_pulse;
  logic [7:0] byte_data, wr_data;
  logic [6:0] wr_addr, ddram_addr;

  hd44780_rx_if bus ();

  hd44780_rx dut (
    .clk         (clk),
    .rst         (rst),
    .lcd         (bus),
    .byte_valid  (byte_valid),
    .byte_rs     (byte_rs),
    .byte_data   (byte_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .ddram_addr  (ddram_addr),
    .mode4       (mode4),
    .clear_pulse (clear_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [3:0] nib;
    logic       exp_valid;
    logic [7:0] exp_byte;
    logic       exp_wr;
    logic [6:0] exp_wr_addr;
    logic       exp_clr;
    logic [6:0] exp_addr;
    logic       exp_mode4;
  } vec_t;

  vec_t vecs[$];

  int tests_run = 0;
  int tests_failed = 0;

  int         got_valid, got_lat, got_wr, got_clr;
  logic [7:0] got_byte, got_wr_data;
  logic       got_rs;
  logic [6:0] got_wr_addr;

  function automatic vec_t mk(input logic r, input logic [3:0] n, input logic v,
                              input logic [7:0] b, input logic w, input logic [6:0] wa,
                              input logic c, input logic [6:0] a, input logic m);
    vec_t t;
    t.rs = r; t.nib = n; t.exp_valid = v; t.exp_byte = b; t.exp_wr = w;
    t.exp_wr_addr = wa; t.exp_clr = c; t.exp_addr = a; t.exp_mode4 = m;
    return t;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One E strobe of two cycles high, then a bounded window observing the outputs.
  task automatic apply_stimulus(input logic r, input logic [3:0] n);
    @(negedge clk);
    bus.rs = r;
    bus.db = n;
    bus.e  = 1'b1;
    repeat (2) @(negedge clk);
    bus.e = 1'b0;
    got_valid = 0; got_lat = 0; got_wr = 0; got_clr = 0;
    got_byte = 8'h00; got_rs = 1'b0; got_wr_addr = 7'h00; got_wr_data = 8'h00;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (byte_valid) begin
        got_valid++;
        got_lat  = k;
        got_byte = byte_data;
        got_rs   = byte_rs;
      end
      if (wr_en) begin
        got_wr++;
        got_wr_addr = wr_addr;
        got_wr_data = wr_data;
      end
      if (clear_pulse) got_clr++;
    end
  endtask

  initial begin
    //            rs  nib  v  byte   w  waddr  c  addr   m4
    vecs.push_back(mk(0, 4'h3, 1, 8'h30, 0, 7'h00, 0, 7'h00, 0));
    vecs.push_back(mk(0, 4'h3, 1, 8'h30, 0, 7'h00, 0, 7'h00, 0));
    vecs.push_back(mk(0, 4'h3, 1, 8'h30, 0, 7'h00, 0, 7'h00, 0));
    vecs.push_back(mk(0, 4'h2, 1, 8'h20, 0, 7'h00, 0, 7'h00, 1));
    vecs.push_back(mk(1, 4'h4, 0, 8'h00, 0, 7'h00, 0, 7'h00, 1));
    vecs.push_back(mk(1, 4'h1, 1, 8'h41, 1, 7'h00, 0, 7'h01, 1));
    vecs.push_back(mk(0, 4'hA, 0, 8'h00, 0, 7'h00, 0, 7'h01, 1));
    vecs.push_back(mk(0, 4'h7, 1, 8'hA7, 0, 7'h00, 0, 7'h27, 1));
    vecs.push_back(mk(1, 4'h5, 0, 8'h00, 0, 7'h00, 0, 7'h27, 1));
    vecs.push_back(mk(1, 4'hA, 1, 8'h5A, 1, 7'h27, 0, 7'h40, 1));
    vecs.push_back(mk(0, 4'h0, 0, 8'h00, 0, 7'h00, 0, 7'h40, 1));
    vecs.push_back(mk(0, 4'h4, 1, 8'h04, 0, 7'h00, 0, 7'h40, 1));
    vecs.push_back(mk(0, 4'h0, 0, 8'h00, 0, 7'h00, 0, 7'h40, 1));
    vecs.push_back(mk(0, 4'h2, 1, 8'h02, 0, 7'h00, 0, 7'h00, 1));
    vecs.push_back(mk(1, 4'h4, 0, 8'h00, 0, 7'h00, 0, 7'h00, 1));
    vecs.push_back(mk(1, 4'h2, 1, 8'h42, 1, 7'h00, 0, 7'h67, 1));
    vecs.push_back(mk(0, 4'hB, 0, 8'h00, 0, 7'h00, 0, 7'h67, 1));
    vecs.push_back(mk(0, 4'h0, 1, 8'hB0, 0, 7'h00, 0, 7'h67, 1));
    vecs.push_back(mk(0, 4'h0, 0, 8'h00, 0, 7'h00, 0, 7'h67, 1));
    vecs.push_back(mk(0, 4'h1, 1, 8'h01, 0, 7'h00, 1, 7'h00, 1));
    vecs.push_back(mk(1, 4'h4, 0, 8'h00, 0, 7'h00, 0, 7'h00, 1));
    vecs.push_back(mk(1, 4'h3, 1, 8'h43, 1, 7'h00, 0, 7'h01, 1));
    vecs.push_back(mk(0, 4'hE, 0, 8'h00, 0, 7'h00, 0, 7'h01, 1));
    vecs.push_back(mk(0, 4'h7, 1, 8'hE7, 0, 7'h00, 0, 7'h67, 1));
    vecs.push_back(mk(1, 4'h4, 0, 8'h00, 0, 7'h00, 0, 7'h67, 1));
    vecs.push_back(mk(1, 4'h4, 1, 8'h44, 1, 7'h67, 0, 7'h00, 1));
    vecs.push_back(mk(0, 4'h3, 0, 8'h00, 0, 7'h00, 0, 7'h00, 1));
    vecs.push_back(mk(0, 4'h0, 1, 8'h30, 0, 7'h00, 0, 7'h00, 0));
    vecs.push_back(mk(1, 4'h6, 1, 8'h60, 1, 7'h00, 0, 7'h01, 0));

    // Reset applied while the bus is active.
    rst = 1'b1;
    bus.e = 1'b1; bus.rs = 1'b1; bus.db = 4'hF;
    repeat (3) @(negedge clk);
    check_output("rst byte_valid", byte_valid, 0);
    check_output("rst byte_rs", byte_rs, 0);
    check_output("rst byte_data", byte_data, 0);
    check_output("rst wr_en", wr_en, 0);
    check_output("rst wr_addr", wr_addr, 0);
    check_output("rst wr_data", wr_data, 0);
    check_output("rst ddram_addr", ddram_addr, 0);
    check_output("rst mode4", mode4, 0);
    check_output("rst clear_pulse", clear_pulse, 0);
    bus.e = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].rs, vecs[i].nib);
      check_output($sformatf("v%0d valid_count", i), got_valid, 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check_output($sformatf("v%0d latency", i), got_lat, EXP_LAT);
        check_output($sformatf("v%0d byte_data", i), got_byte, vecs[i].exp_byte);
        check_output($sformatf("v%0d byte_rs", i), got_rs, vecs[i].rs);
      end
      check_output($sformatf("v%0d wr_count", i), got_wr, 32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr) begin
        check_output($sformatf("v%0d wr_addr", i), got_wr_addr, vecs[i].exp_wr_addr);
        check_output($sformatf("v%0d wr_data", i), got_wr_data, vecs[i].exp_byte);
      end
      check_output($sformatf("v%0d clear_count", i), got_clr, 32'(vecs[i].exp_clr));
      check_output($sformatf("v%0d ddram_addr", i), ddram_addr, vecs[i].exp_addr);
      check_output($sformatf("v%0d mode4", i), mode4, vecs[i].exp_mode4);
    end

    // Reset in the middle of a 4-bit transfer drops the latched high nibble.
    apply_stimulus(1'b0, 4'h2);
    check_output("mid enter4 byte", got_byte, 8'h20);
    check_output("mid enter4 mode4", mode4, 1);
    apply_stimulus(1'b0, 4'h4);
    check_output("mid hi valid_count", got_valid, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_output("mid rst mode4", mode4, 0);
    check_output("mid rst ddram_addr", ddram_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(1'b0, 4'h3);
    check_output("mid post valid_count", got_valid, 1);
    check_output("mid post byte_data", got_byte, 8'h30);
    check_output("mid post latency", got_lat, EXP_LAT);
    check_output("mid post mode4", mode4, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hd44780_rx.md
# hd44780_rx

Receiver-side model of an HD44780 character-LCD controller. Watches the E/RS/DB[7:4] bus driven by the team's HD44780 driver and reassembles transferred bytes, tracking 8-bit/4-bit interface mode like the real controller. Decodes the DDRAM-addressing subset of the command set and emits a display-memory write port. Used as a loopback/self-check partner for the driver on-chip and as the responder in simulation benches.

## Interface
- `LINE_LEN`, 40: characters per display line; last valid address in a line is `LINE_LEN-1`.
- `LINE2_BASE`, 7'h40: DDRAM base address of line 2.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `e` input 1: HD44780 enable strobe; data latched on its falling edge.
- `rs` input 1: register select; 0 = command, 1 = data.
- `db` input 4: data bus D7..D4.
- `byte_valid` output 1: one-cycle pulse per assembled byte.
- `byte_rs` output 1: RS of the assembled byte.
- `byte_data` output 8: assembled byte.
- `wr_en` output 1: one-cycle DDRAM write pulse (data bytes only).
- `wr_addr` output 7: DDRAM address of the write (pre-update).
- `wr_data` output 8: character written.
- `ddram_addr` output 7: current address counter.
- `mode4` output 1: 1 = 4-bit interface active.
- `clear_pulse` output 1: one-cycle pulse on Clear Display.

## Operation
- Falling edge of `e` (registered previous value 1, current 0) latches `rs` and `db`.
- States: MODE8, MODE4_HI, MODE4_LO.
- MODE8: each edge yields byte `{db,4'h0}`; stay MODE8 unless byte is Function Set with DL=0 (`8'b001_0xxxx`) -> MODE4_HI.
- MODE4_HI: latch high nibble -> MODE4_LO. MODE4_LO: byte = `{hi,db}`, `byte_rs` = RS at low-nibble edge -> MODE4_HI; Function Set with DL=1 -> MODE8.
- Command decode (`byte_rs`=0): `0x01` clear: `ddram_addr`=0, I/D=1, `clear_pulse`. `0x02/0x03` home: `ddram_addr`=0. `0x04-0x07` entry mode: I/D=bit1. `0x80|a`: load `a` if in `[0,LINE_LEN-1]` or `[LINE2_BASE,LINE2_BASE+LINE_LEN-1]`, else ignored. All other commands pass to byte stream only.
- Data (`byte_rs`=1): `wr_en`, `wr_addr`=current, `wr_data`=byte; address steps by I/D.
- Increment wrap: `LINE_LEN-1` -> `LINE2_BASE`; `LINE2_BASE+LINE_LEN-1` -> 0. Decrement is the inverse: 0 -> `LINE2_BASE+LINE_LEN-1`; `LINE2_BASE` -> `LINE_LEN-1`.
- Reset values: state MODE8, I/D=1, `ddram_addr`=0, all pulses 0, `byte_data`/`wr_data`=0, `byte_rs`=0, `wr_addr`=0, `mode4`=0.
- Reset mid-byte discards any latched high nibble; the next edge is treated as MODE8.

## Timing
- With synchronizer: `byte_valid`/`wr_en`/`clear_pulse` high on 3rd rising `clk` edge after `e` falls (2 sync + 1 output register). Without: 1st edge.
- `ddram_addr`, `mode4` update on the same edge the pulse asserts.
- Minimum `e` high and low time: 2 `clk` cycles each; shorter pulses are undefined.
- `rs`/`db` must be stable one `clk` before `e` falls and until it has fallen; they share `e`'s pipeline depth.

## Configuration
- `HD44780_RX_SYNC_EN` defined: two-flop synchronizers on `e`, `rs`, `db`; 3-cycle latency, safe for asynchronous pins.
- Undefined: inputs used directly (same clock domain only); 1-cycle latency; all other behaviour identical.

## Structure
- `hd44780_pkg`: state enum, command opcodes/masks (CLEAR, HOME, ENTRY, FUNCSET, SETDDRAM), DL/I-D bit positions.
- Sub-module `hd44780_rx_sync`: optional synchronizer plus `e` falling-edge detector, emitting `fall`, `rs_s`, `db_s`.

## Test plan
- Reset asserted with bus active -> all outputs at reset values, `mode4`=0, `ddram_addr`=0.
- Nibbles 3,3,3,2 (RS=0) in MODE8 -> four `byte_valid` with `byte_data` 0x30,0x30,0x30,0x20; `mode4`=1 after the fourth.
- In 4-bit mode send 0x4 then 0x1 with RS=1 -> `byte_data`=0x41, `wr_en`, `wr_addr`=0x00, `ddram_addr`=0x01.
- Command 0xA7, then data 0x5A -> `wr_addr`=0x27, `ddram_addr`=0x40; entry 0x04, home, data -> `wr_addr`=0x00, `ddram_addr`=0x67.
- Command 0xB0 (address 0x30) -> ignored, `ddram_addr` unchanged; command 0x01 -> `clear_pulse`, `ddram_addr`=0, I/D=1.
- 4-bit mode, send high nibble 0x4, assert `rst`, send nibble 0x3 -> `byte_data`=0x30, `mode4`=0.
